// File: rtl/varredura_display_placar_pkg.sv
// Shared constants and types for the scoreboard display scan path:
// anode codes, segment patterns, mode encoding and the display payload.
package varredura_display_placar_pkg;

    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Segment patterns g..a, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {
        MODO_PLACAR = 1'b0,
        MODO_CRONO  = 1'b1
    } modo_t;

    typedef struct packed {
        logic [3:0] anodos;
        logic [6:0] segmentos;
    } display_t;

    localparam display_t DISPLAY_OFF = '{anodos: AN_OFF, segmentos: SEG_BLANK};

    // Counter width able to hold 0..n-1, never below one bit
    function automatic int unsigned largura(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_para_7seg.sv
// BCD digit to active-low 7-segment pattern (g..a); non-decimal codes blank.
module bcd_para_7seg
    import varredura_display_placar_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segmentos_c
);

    always_comb begin
        segmentos_c = SEG_BLANK;
        case (bcd)
            4'd0:    segmentos_c = SEG_0;
            4'd1:    segmentos_c = SEG_1;
            4'd2:    segmentos_c = SEG_2;
            4'd3:    segmentos_c = SEG_3;
            4'd4:    segmentos_c = SEG_4;
            4'd5:    segmentos_c = SEG_5;
            4'd6:    segmentos_c = SEG_6;
            4'd7:    segmentos_c = SEG_7;
            4'd8:    segmentos_c = SEG_8;
            4'd9:    segmentos_c = SEG_9;
            default: segmentos_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/varredura_display_placar.sv
// Multiplexed 4-digit display scanner alternating between scoreboard (all four
// digits) and stopwatch (middle two digits), with anti-ghosting blank per slot.
module varredura_display_placar
    import varredura_display_placar_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DIV_DIGIT    = CLK_HZ / 480,
    parameter int unsigned MODE_TICKS   = 2 * CLK_HZ,
    parameter int unsigned BLANK_CYCLES = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] placar_t1_dez,
    input  logic [3:0] placar_t1_uni,
    input  logic [3:0] placar_t2_dez,
    input  logic [3:0] placar_t2_uni,
    input  logic [3:0] crono_dez,
    input  logic [3:0] crono_uni,
    input  logic       forcar_placar,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       modo_crono
);

    localparam int unsigned P_W   = largura(DIV_DIGIT);
    localparam int unsigned M_W   = largura(MODE_TICKS);
    localparam int unsigned IDX_W = 2;

    localparam logic [P_W-1:0] P_ULTIMO = P_W'(DIV_DIGIT - 1);
    localparam logic [M_W-1:0] M_ULTIMO = M_W'(MODE_TICKS - 1);

    modo_t            modo, modo_prox;
    logic [P_W-1:0]   p, p_prox;
    logic [M_W-1:0]   m, m_prox;
    logic [IDX_W-1:0] idx, idx_prox;
    display_t         saida, saida_prox;

    logic [3:0]       digito;
    logic [3:0]       anodo_sel;
    logic [6:0]       seg_digito;
    logic             em_branco;

    // State and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            modo  <= MODO_PLACAR;
            p     <= '0;
            m     <= '0;
            idx   <= '0;
            saida <= DISPLAY_OFF;
        end else begin
            modo  <= modo_prox;
            p     <= p_prox;
            m     <= m_prox;
            idx   <= idx_prox;
            saida <= saida_prox;
        end
    end

    // Next state: forced return, mode switch, then ordinary slot stepping
    always_comb begin
        modo_prox = modo;
        p_prox    = p;
        m_prox    = m;
        idx_prox  = idx;
        if (forcar_placar && (modo == MODO_CRONO)) begin
            modo_prox = MODO_PLACAR;
            p_prox    = '0;
            m_prox    = '0;
            idx_prox  = '0;
        end else if (!forcar_placar && (m == M_ULTIMO)) begin
            modo_prox = (modo == MODO_PLACAR) ? MODO_CRONO : MODO_PLACAR;
            p_prox    = '0;
            m_prox    = '0;
            idx_prox  = '0;
        end else begin
            m_prox = forcar_placar ? '0 : m + M_W'(1);
            if (p == P_ULTIMO) begin
                p_prox = '0;
                if (modo == MODO_CRONO) begin
                    idx_prox = (idx == IDX_W'(1)) ? '0 : idx + IDX_W'(1);
                end else begin
                    idx_prox = idx + IDX_W'(1);
                end
            end else begin
                p_prox = p + P_W'(1);
            end
        end
    end

    // Digit and anode selection for the current slot
    always_comb begin
        digito    = 4'hF;
        anodo_sel = AN_OFF;
        case ({modo, idx})
            {MODO_PLACAR, 2'd0}: begin anodo_sel = AN_D3; digito = placar_t1_dez; end
            {MODO_PLACAR, 2'd1}: begin anodo_sel = AN_D2; digito = placar_t1_uni; end
            {MODO_PLACAR, 2'd2}: begin anodo_sel = AN_D1; digito = placar_t2_dez; end
            {MODO_PLACAR, 2'd3}: begin anodo_sel = AN_D0; digito = placar_t2_uni; end
            {MODO_CRONO,  2'd0}: begin anodo_sel = AN_D2; digito = crono_dez;     end
            {MODO_CRONO,  2'd1}: begin anodo_sel = AN_D1; digito = crono_uni;     end
            default: begin
                anodo_sel = AN_OFF;
                digito    = 4'hF;
            end
        endcase
    end

    bcd_para_7seg u_decod (
        .bcd         (digito),
        .segmentos_c (seg_digito)
    );

    always_comb begin
        em_branco  = 32'(p) < BLANK_CYCLES;
        saida_prox = DISPLAY_OFF;
        if (!em_branco && (anodo_sel != AN_OFF)) begin
            saida_prox.anodos    = anodo_sel;
            saida_prox.segmentos = seg_digito;
        end
    end

    assign anodos     = saida.anodos;
    assign segmentos  = saida.segmentos;
    assign modo_crono = (modo == MODO_CRONO);

endmodule

// File: tb/tb_varredura_display_placar.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// cycle-count based reference model of the display scan.
module tb_varredura_display_placar;

    localparam int unsigned DIV   = 4;
    localparam int unsigned MT    = 64;
    localparam int unsigned BL    = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] t1d, t1u, t2d, t2u, cd, cu;
    logic       forcar;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       modo_crono;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] seg_tab [16];

    // Reference model: phase counts cycles since the slot origin, mc since mode start
    int   ph, mc;
    bit   md;
    logic [3:0] e_an;
    logic [6:0] e_seg;

    always #5 clock = ~clock;

    varredura_display_placar #(
        .CLK_HZ       (50_000_000),
        .DIV_DIGIT    (DIV),
        .MODE_TICKS   (MT),
        .BLANK_CYCLES (BL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .placar_t1_dez (t1d),
        .placar_t1_uni (t1u),
        .placar_t2_dez (t2d),
        .placar_t2_uni (t2u),
        .crono_dez     (cd),
        .crono_uni     (cu),
        .forcar_placar (forcar),
        .anodos        (anodos),
        .segmentos     (segmentos),
        .modo_crono    (modo_crono)
    );

    task automatic verificar(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %h required %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int slot, pos;
        logic [3:0] dig;
        if (reset) begin
            md = 0; ph = 0; mc = 0;
            e_an = 4'b1111; e_seg = 7'h7F;
        end else begin
            slot = ph / DIV;
            pos  = ph % DIV;
            dig  = 4'hF;
            if (pos < BL) begin
                e_an = 4'b1111;
            end else if (!md) begin
                case (slot % 4)
                    0: begin e_an = 4'b0111; dig = t1d; end
                    1: begin e_an = 4'b1011; dig = t1u; end
                    2: begin e_an = 4'b1101; dig = t2d; end
                    default: begin e_an = 4'b1110; dig = t2u; end
                endcase
            end else begin
                if (slot % 2 == 0) begin e_an = 4'b1011; dig = cd; end
                else               begin e_an = 4'b1101; dig = cu; end
            end
            e_seg = (e_an == 4'b1111) ? 7'h7F : seg_tab[dig];
            if (forcar) begin
                mc = 0;
                if (md) begin md = 0; ph = 0; end
                else ph++;
            end else if (mc == MT - 1) begin
                md = !md; ph = 0; mc = 0;
            end else begin
                mc++; ph++;
            end
        end
    endtask

    task automatic step();
        int zeros;
        @(posedge clock);
        model_step();
        @(negedge clock);
        verificar("anodos", 16'(anodos), 16'(e_an));
        verificar("segmentos", 16'(segmentos), 16'(e_seg));
        verificar("modo_crono", 16'(modo_crono), 16'(md));
        zeros = 0;
        for (int i = 0; i < 4; i++) if (anodos[i] == 1'b0) zeros++;
        verificar("one_anode", 16'(zeros <= 1), 16'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        bit achou;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

        reset = 1'b1; forcar = 1'b0;
        t1d = 4'd1; t1u = 4'd2; t2d = 4'd3; t2u = 4'd4; cd = 4'd5; cu = 4'd9;
        run(3);
        verificar("reset_anodos", 16'(anodos), 16'h000F);
        verificar("reset_segmentos", 16'(segmentos), 16'h007F);
        reset = 1'b0;

        // First slot after reset: one blank then digit "1" on the leftmost position
        step();
        verificar("first_blank", 16'(anodos), 16'h000F);
        step();
        verificar("first_digit_an", 16'(anodos), 16'(4'b0111));
        verificar("first_digit_seg", 16'(segmentos), 16'(7'b1111001));

        // Scoreboard period, stopwatch period, and back
        run(140);

        // Force scoreboard during stopwatch, hold, release, measure switch latency
        achou = 0;
        for (int i = 0; i < 200 && !achou; i++) begin
            step();
            if (md && mc > 5) achou = 1;
        end
        verificar("wait_crono", 16'(achou), 16'd1);
        forcar = 1'b1;
        step();
        verificar("force_mode", 16'(modo_crono), 16'd0);
        run(210);
        forcar = 1'b0;
        n = 0;
        achou = 0;
        for (int i = 0; i < 200 && !achou; i++) begin
            step();
            n++;
            if (modo_crono) achou = 1;
        end
        verificar("release_latency", 16'(n), 16'd64);

        // Non-decimal digit blanks its slot
        t2u = 4'hB;
        run(200);
        t2u = 4'd4;

        // Reset mid-slot at idx2 in scoreboard mode
        achou = 0;
        for (int i = 0; i < 300 && !achou; i++) begin
            step();
            if (!md && ((ph / DIV) % 4 == 2) && (ph % DIV == 2)) achou = 1;
        end
        verificar("wait_idx2", 16'(achou), 16'd1);
        reset = 1'b1;
        step();
        verificar("midslot_reset_an", 16'(anodos), 16'h000F);
        reset = 1'b0;
        step();
        step();
        verificar("restart_an", 16'(anodos), 16'(4'b0111));

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                t1d = 4'($urandom_range(0, 15)); t1u = 4'($urandom_range(0, 15));
                t2d = 4'($urandom_range(0, 15)); t2u = 4'($urandom_range(0, 15));
                cd  = 4'($urandom_range(0, 15)); cu  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 2) forcar = ~forcar;
            reset = ($urandom_range(0, 999) < 3);
            step();
        end
        reset = 1'b0;
        forcar = 1'b0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/varredura_display_placar.md
Name: varredura_display_placar

Overview:
- Sequential producer of the 4-digit 7-segment display timing and data for the basketball scoreboard.
- Generates from the system clock the scan strobe and the 2 s scoreboard/stopwatch alternation, and drives active-low digit enables plus matching segment patterns.
- In scoreboard mode all four digits are scanned: T1 on digits 3,2 and T2 on digits 1,0. In stopwatch mode only the two middle digits are scanned.
- Sits between the score/stopwatch counters and the board pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- DIV_DIGIT, 104166, clock cycles per digit slot (~480 Hz step rate). Must be >= 2.
- MODE_TICKS, 100000000, clock cycles per mode period (2 s).
- BLANK_CYCLES, 512, cycles at the start of each slot with all digits off (anti-ghosting). Must be < DIV_DIGIT.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- placar_t1_dez  in  4  T1 tens digit, BCD.
- placar_t1_uni  in  4  T1 units digit, BCD.
- placar_t2_dez  in  4  T2 tens digit, BCD.
- placar_t2_uni  in  4  T2 units digit, BCD.
- crono_dez  in  4  stopwatch tens digit, BCD.
- crono_uni  in  4  stopwatch units digit, BCD.
- forcar_placar  in  1  holds scoreboard mode while high.
- anodos  out  4  digit enables, active-low, bit3 = leftmost digit.
- segmentos  out  7  segments g..a, active-low.
- modo_crono  out  1  1 = stopwatch mode is being displayed.

Behaviour:
- Single clock; reset is synchronous, active-high. All state and outputs are registered.
- Reset values: modo_crono=0, anodos=4'b1111, segmentos=7'b1111111. Internal slot counter p=0, digit index idx=0, mode counter m=0.
- Slot counter p:
  - Counts 0..DIV_DIGIT-1 and wraps.
  - At wrap, idx advances: in scoreboard mode 0→1→2→3→0; in stopwatch mode 0→1→0.
- Mode counter m:
  - Counts 0..MODE_TICKS-1.
  - At terminal, modo_crono toggles, idx=0, p=0 and m=0.
  - Mode switch has priority over a simultaneous slot wrap.
- forcar_placar=1:
  - m is held at 0 and the mode is scoreboard.
  - If the mode was stopwatch, it switches to scoreboard on the next edge with idx=0, p=0.
  - On release, counting resumes from m=0.
- Output register (1-cycle latency from state):
  - If p < BLANK_CYCLES: anodos=1111, segmentos=1111111.
  - Otherwise, scoreboard mode:
    - idx0: anodos=0111, shows t1_dez.
    - idx1: anodos=1011, shows t1_uni.
    - idx2: anodos=1101, shows t2_dez.
    - idx3: anodos=1110, shows t2_uni.
  - Otherwise, stopwatch mode:
    - idx0: anodos=1011, shows crono_dez.
    - idx1: anodos=1101, shows crono_uni.
- Exactly one anode is low outside blanking.
- Segment decode is active-low standard: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - BCD values 10..15 give blank (1111111).
- Digit inputs are sampled when the output register loads (no extra capture). A change mid-slot appears on the next edge.
- Reset mid-slot: outputs go blank on that same edge. Scanning then restarts at scoreboard idx0.

Decomposition:
- Shared package holds:
  - anode codes AN_D3=0111, AN_D2=1011, AN_D1=1101, AN_D0=1110, AN_OFF=1111;
  - SEG_BLANK and the digit segment constants;
  - the mode encoding (MODO_PLACAR=0, MODO_CRONO=1).
- One combinational sub-module, bcd_para_7seg (4-bit BCD → 7-bit active-low), shared with other display paths.

Test Plan (DIV_DIGIT=4, MODE_TICKS=64, BLANK_CYCLES=1):
- Reset with digits T1=12, T2=34 → anodos=1111, segmentos=1111111, modo_crono=0 while reset high.
- Release reset →
  - one blank cycle, then 3 cycles of 0111/1111001 ("1");
  - then blank, 1011/0100100 ("2");
  - then blank, 1101/0110000 ("3");
  - then blank, 1110/0011001 ("4");
  - then repeats.
- Run to m terminal with crono=59 →
  - modo_crono=1 and the next slot starts at idx0;
  - 1011/0010010 ("5"), then 1101/0010000 ("9");
  - anodes 0111 and 1110 never appear during the 64-cycle stopwatch period.
- Assert forcar_placar during stopwatch mode → next edge modo_crono=0, idx0. Mode stays scoreboard for ≥200 cycles. After release, the switch occurs exactly 64 cycles later.
- Set t2_uni=4'hB → its slot shows 1110 with segmentos=1111111. Every cycle has at most one low anode bit.
- Assert reset for one cycle mid-slot (idx2) → blank outputs, then the sequence restarts at 0111 after one blank cycle.
